// File: rtl/cache_control.sv
// Control FSM for a 2-way, write-back, write-allocate cache with 128-bit lines.
// The FSM sequences hit handling, dirty-victim write-back and line allocation.
module cache_control (
  input  logic clk,
  input  logic rst_n,
  input  logic mem_read,
  input  logic mem_write,
  output logic mem_resp,
  output logic pmem_read,
  output logic pmem_write,
  input  logic pmem_resp,
  input  logic hit1,
  input  logic hit2,
  input  logic dirty1_out,
  input  logic dirty2_out,
  input  logic lru_out,
  output logic load_tag1,
  output logic load_tag2,
  output logic load_valid1,
  output logic load_valid2,
  output logic load_data1,
  output logic load_data2,
  output logic load_dirty1,
  output logic load_dirty2,
  output logic load_lru,
  output logic valid_in,
  output logic dirty_in,
  output logic lru_in,
  output logic data_sel,
  output logic pmem_addr_sel,
  output logic wb_way
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    ALLOCATE  = 2'd2
  } state_t;

  state_t state;
  logic   victim;
  logic   req;
  logic   hit;
  logic   victim_dirty;

  assign req          = mem_read | mem_write;
  assign hit          = hit1 | hit2;
  assign victim_dirty = lru_out ? dirty2_out : dirty1_out;

  // State and victim register; victim is captured once at miss detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      victim <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req && !hit) begin
            victim <= lru_out;
            state  <= victim_dirty ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: begin
          // An abandoned request skips the fill once the write-back lands.
          if (pmem_resp) state <= req ? ALLOCATE : IDLE;
        end
        ALLOCATE: begin
          if (pmem_resp) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode from state, victim and live inputs; reset forces everything low.
  always_comb begin
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    load_tag1     = 1'b0;
    load_tag2     = 1'b0;
    load_valid1   = 1'b0;
    load_valid2   = 1'b0;
    load_data1    = 1'b0;
    load_data2    = 1'b0;
    load_dirty1   = 1'b0;
    load_dirty2   = 1'b0;
    load_lru      = 1'b0;
    valid_in      = 1'b0;
    dirty_in      = 1'b0;
    lru_in        = 1'b0;
    data_sel      = 1'b0;
    pmem_addr_sel = 1'b0;
    wb_way        = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (req && hit) begin
            mem_resp = 1'b1;
            load_lru = 1'b1;
            lru_in   = hit1;
            if (mem_write) begin
              dirty_in    = 1'b1;
              load_data1  = hit1;
              load_dirty1 = hit1;
              load_data2  = !hit1;
              load_dirty2 = !hit1;
            end
          end
        end
        WRITEBACK: begin
          pmem_write    = 1'b1;
          pmem_addr_sel = 1'b1;
          wb_way        = victim;
        end
        ALLOCATE: begin
          pmem_read = 1'b1;
          wb_way    = victim;
          if (pmem_resp) begin
            data_sel    = 1'b1;
            valid_in    = 1'b1;
            load_data1  = !victim;
            load_tag1   = !victim;
            load_valid1 = !victim;
            load_dirty1 = !victim;
            load_data2  = victim;
            load_tag2   = victim;
            load_valid2 = victim;
            load_dirty2 = victim;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_control.sv
// Directed bench for cache_control: per-cycle comparison against a transaction
// model of the miss/hit protocol plus hand-computed spot checks.
module tb_cache_control;

  logic clk = 1'b0;
  logic rst_n, mem_read, mem_write, pmem_resp, hit1, hit2, dirty1_out, dirty2_out, lru_out;
  logic mem_resp, pmem_read, pmem_write;
  logic load_tag1, load_tag2, load_valid1, load_valid2, load_data1, load_data2;
  logic load_dirty1, load_dirty2, load_lru, valid_in, dirty_in, lru_in;
  logic data_sel, pmem_addr_sel, wb_way;

  int checks = 0;
  int passes = 0;
  int pmem_read_cycles;
  bit checking = 1'b0;

  always #5 clk = ~clk;

  cache_control dut (
    .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_resp(pmem_resp), .hit1(hit1), .hit2(hit2),
    .dirty1_out(dirty1_out), .dirty2_out(dirty2_out), .lru_out(lru_out),
    .load_tag1(load_tag1), .load_tag2(load_tag2),
    .load_valid1(load_valid1), .load_valid2(load_valid2),
    .load_data1(load_data1), .load_data2(load_data2),
    .load_dirty1(load_dirty1), .load_dirty2(load_dirty2),
    .load_lru(load_lru), .valid_in(valid_in), .dirty_in(dirty_in), .lru_in(lru_in),
    .data_sel(data_sel), .pmem_addr_sel(pmem_addr_sel), .wb_way(wb_way)
  );

  logic [17:0] dut_vec;
  assign dut_vec = {mem_resp, pmem_read, pmem_write, load_tag1, load_tag2,
                    load_valid1, load_valid2, load_data1, load_data2,
                    load_dirty1, load_dirty2, load_lru, valid_in, dirty_in,
                    lru_in, data_sel, pmem_addr_sel, wb_way};

  // Transaction model: is a write-back or a line fill outstanding, and for which way.
  bit wb_pending   = 1'b0;
  bit fill_pending = 1'b0;
  bit model_way    = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      wb_pending   <= 1'b0;
      fill_pending <= 1'b0;
      model_way    <= 1'b0;
    end else if (wb_pending) begin
      if (pmem_resp) begin
        wb_pending   <= 1'b0;
        fill_pending <= (mem_read || mem_write);
      end
    end else if (fill_pending) begin
      if (pmem_resp) fill_pending <= 1'b0;
    end else if ((mem_read || mem_write) && !(hit1 || hit2)) begin
      model_way <= lru_out;
      if ((lru_out == 1'b0 && dirty1_out) || (lru_out == 1'b1 && dirty2_out))
        wb_pending <= 1'b1;
      else
        fill_pending <= 1'b1;
    end
  end

  function automatic logic [17:0] model_outs();
    logic e_resp, e_prd, e_pwr, e_lru, e_vin, e_din, e_lin, e_dsel, e_asel, e_way;
    logic [1:0] e_tag, e_valid, e_data, e_dirty;  // index 0 = way 1, 1 = way 2
    int w;
    {e_resp, e_prd, e_pwr, e_lru, e_vin, e_din, e_lin, e_dsel, e_asel, e_way} = '0;
    e_tag = '0; e_valid = '0; e_data = '0; e_dirty = '0;
    if (rst_n) begin
      if (wb_pending) begin
        e_pwr = 1'b1; e_asel = 1'b1; e_way = model_way;
      end else if (fill_pending) begin
        e_prd = 1'b1; e_way = model_way;
        if (pmem_resp) begin
          w = int'(model_way);
          e_tag[w] = 1'b1; e_valid[w] = 1'b1; e_data[w] = 1'b1; e_dirty[w] = 1'b1;
          e_dsel = 1'b1; e_vin = 1'b1;
        end
      end else if ((mem_read || mem_write) && (hit1 || hit2)) begin
        w = hit1 ? 0 : 1;
        e_resp = 1'b1; e_lru = 1'b1;
        e_lin = (w == 0);
        if (mem_write) begin
          e_data[w] = 1'b1; e_dirty[w] = 1'b1; e_din = 1'b1;
        end
      end
    end
    return {e_resp, e_prd, e_pwr, e_tag[0], e_tag[1], e_valid[0], e_valid[1],
            e_data[0], e_data[1], e_dirty[0], e_dirty[1], e_lru, e_vin, e_din,
            e_lin, e_dsel, e_asel, e_way};
  endfunction

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (checking) begin
      logic [17:0] exp_vec;
      exp_vec = model_outs();
      checks++;
      if (dut_vec === exp_vec) passes++;
      else $display("FAIL cycle_outputs t=%0t got=%b exp=%b", $time, dut_vec, exp_vec);
    end
  end

  task automatic chk(input string name, input logic got, input logic exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%b exp=%b", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic rd, input logic wr, input logic h1, input logic h2,
                        input logic d1, input logic d2, input logic lru, input logic pr);
    mem_read = rd; mem_write = wr; hit1 = h1; hit2 = h2;
    dirty1_out = d1; dirty2_out = d2; lru_out = lru; pmem_resp = pr;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(1, 0, 1, 0, 0, 0, 0, 0);
    checking = 1'b1;
    step(); step();
    chk("reset_outputs_zero", |dut_vec, 1'b0);

    // Read hit way 2
    rst_n = 1'b1;
    set_in(1, 0, 0, 1, 0, 0, 0, 0);
    chk("rd_hit2_resp", mem_resp, 1'b1);
    chk("rd_hit2_lru_in", lru_in, 1'b0);
    chk("rd_hit2_no_data", load_data2, 1'b0);
    step();

    // Write hit way 1, then both hits, then read+write together
    set_in(0, 1, 1, 0, 0, 0, 0, 0);
    chk("wr_hit1_data", load_data1, 1'b1);
    chk("wr_hit1_dirty_in", dirty_in, 1'b1);
    chk("wr_hit1_lru_in", lru_in, 1'b1);
    step();
    set_in(0, 1, 1, 1, 0, 0, 1, 0);
    chk("both_hits_way1", load_data1 & ~load_data2, 1'b1);
    step();
    set_in(1, 1, 0, 1, 0, 0, 0, 0);
    chk("rdwr_is_write", load_dirty2, 1'b1);
    step();

    // Clean read miss into way 2, pmem takes 3 cycles
    set_in(1, 0, 0, 0, 1, 0, 1, 0);
    chk("miss_no_resp", mem_resp, 1'b0);
    step();
    pmem_read_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 0, 0, 0, 1, 0, 1, (i == 2));
      pmem_read_cycles += int'(pmem_read);
      if (i == 2) begin
        chk("fill2_load", load_data2 & load_tag2 & load_valid2 & load_dirty2, 1'b1);
        chk("fill2_sel_valid", data_sel & valid_in & ~dirty_in, 1'b1);
      end
      step();
    end
    checks++;
    if (pmem_read_cycles == 3) passes++;
    else $display("FAIL pmem_read_cycles got=%0d exp=3", pmem_read_cycles);
    set_in(1, 0, 0, 1, 1, 0, 1, 0);
    chk("refill_hit_resp", mem_resp, 1'b1);
    step();

    // Dirty write miss on way 1; lru toggles mid write-back
    set_in(0, 1, 0, 0, 1, 0, 0, 0);
    step();
    set_in(0, 1, 0, 0, 1, 0, 1, 0);
    chk("wb_pmem_write", pmem_write & pmem_addr_sel & ~pmem_read, 1'b1);
    chk("wb_way", wb_way, 1'b0);
    step();
    set_in(0, 1, 0, 0, 1, 0, 0, 0);
    step();
    set_in(0, 1, 0, 0, 1, 0, 1, 1);
    step();
    set_in(0, 1, 0, 0, 1, 0, 1, 1);
    chk("alloc_orig_victim", load_data1 & ~load_data2, 1'b1);
    step();
    set_in(0, 1, 1, 0, 0, 0, 1, 0);
    chk("wr_after_fill_resp", mem_resp & load_data1, 1'b1);
    step();

    // Reset during allocate
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    step();
    chk("alloc_pmem_read", pmem_read, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_alloc_zero", |dut_vec, 1'b0);
    step();
    rst_n = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    chk("idle_ignores_pmem_resp", |dut_vec, 1'b0);
    step();

    // Strobe drops mid write-back: back to idle without a fill
    set_in(1, 0, 0, 0, 0, 1, 1, 0);
    step();
    set_in(0, 0, 0, 0, 0, 1, 1, 0);
    step();
    set_in(0, 0, 0, 0, 0, 1, 1, 1);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    chk("abandon_wb_idle", pmem_read | pmem_write | mem_resp, 1'b0);
    step();

    // Strobe drops mid allocate
    set_in(0, 1, 0, 0, 0, 0, 0, 0);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 1);
    step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();

    checking = 1'b0;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
